// File: rtl/code_lock_n.sv
// Digit-entry code lock: LOCKED/UNLOCKED/ERROR/LOCKOUT/PROGRAM with reprogrammable code.
// Latency: outputs reflect a press on the edge that samples it; all outputs registered.
// Backpressure: none; presses are edge-detected on enter, extra presses in LOCKOUT are dropped.
module code_lock_n #(
    parameter int CODE_LEN       = 4,
    parameter int DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int UNLOCK_CYCLES  = 500
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DIGIT_W-1:0]                 digit,
    input  logic                               enter,
    input  logic                               prog,
    output logic                               locked_led,
    output logic                               unlocked_led,
    output logic                               error_led,
    output logic                               lockout_led,
    output logic [2:0]                         state_code,
    output logic [2:0]                         digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left
);

    localparam int TW    = $clog2(MAX_TRIES + 1);
    localparam int TMAX  = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int CW    = CODE_LEN * DIGIT_W;

    localparam logic [2:0]       LAST      = 3'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0] LOCK_END  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] UNL_END   = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]    TRIES_MAX = TW'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_UNLOCKED = 3'd1,
        ST_ERROR    = 3'd2,
        ST_LOCKOUT  = 3'd3,
        ST_PROGRAM  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               enter_q;
    logic [2:0]         cnt_q, cnt_d;
    logic               mism_q, mism_d;
    logic [TW-1:0]      tries_q, tries_d, tries_dec;
    logic [TMR_W-1:0]   tmr_q, tmr_d, tmr_inc;
    logic [CW-1:0]      code_q, code_d;
    logic [CW-1:0]      shadow_q, shadow_d, shadow_wr;
    logic [DIGIT_W-1:0] cur_digit;
    logic               press;
    logic               digit_ok;

    assign press     = enter & ~enter_q;
    assign tries_dec = (tries_q == '0) ? '0 : tries_q - TW'(1);
    assign tmr_inc   = tmr_q + TMR_W'(1);
    assign digit_ok  = (digit == cur_digit);

    // First digit lives in the most-significant field of the code word.
    always_comb begin
        cur_digit = '0;
        shadow_wr = shadow_q;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (cnt_q == 3'(i)) begin
                cur_digit = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
                shadow_wr[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mism_d   = mism_q;
        tries_d  = tries_q;
        tmr_d    = tmr_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_LOCKED: begin
                if (press) begin
                    if (cnt_q == LAST) begin
                        cnt_d  = '0;
                        mism_d = 1'b0;
                        tmr_d  = '0;
                        if (!mism_q && digit_ok) begin
                            state_d = ST_UNLOCKED;
                            tries_d = TRIES_MAX;
                        end else begin
                            tries_d = tries_dec;
                            state_d = (tries_dec == '0) ? ST_LOCKOUT : ST_ERROR;
                        end
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        mism_d = mism_q | ~digit_ok;
                    end
                end
            end
            ST_ERROR: begin
                if (press) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_q >= LOCK_END) begin
                    state_d = ST_LOCKED;
                    tries_d = TRIES_MAX;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            ST_UNLOCKED: begin
                if (press) begin
                    tmr_d = '0;
                    cnt_d = '0;
                    state_d = prog ? ST_PROGRAM : ST_LOCKED;
                end else if (tmr_q >= UNL_END) begin
                    state_d = ST_LOCKED;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            ST_PROGRAM: begin
                if (press) begin
                    shadow_d = shadow_wr;
                    tmr_d    = '0;
                    if (cnt_q == LAST) begin
                        // Full new code committed in one edge, including the final digit.
                        code_d  = shadow_wr;
                        cnt_d   = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (tmr_q >= UNL_END) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: begin
                state_d = ST_LOCKED;
                cnt_d   = '0;
                mism_d  = 1'b0;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOCKED;
            enter_q      <= 1'b0;
            cnt_q        <= '0;
            mism_q       <= 1'b0;
            tries_q      <= TRIES_MAX;
            tmr_q        <= '0;
            code_q       <= DEFAULT_CODE;
            shadow_q     <= DEFAULT_CODE;
            locked_led   <= 1'b1;
            unlocked_led <= 1'b0;
            error_led    <= 1'b0;
            lockout_led  <= 1'b0;
        end else begin
            state_q      <= state_d;
            enter_q      <= enter;
            cnt_q        <= cnt_d;
            mism_q       <= mism_d;
            tries_q      <= tries_d;
            tmr_q        <= tmr_d;
            code_q       <= code_d;
            shadow_q     <= shadow_d;
            locked_led   <= (state_d == ST_LOCKED);
            unlocked_led <= (state_d == ST_UNLOCKED) || (state_d == ST_PROGRAM);
            error_led    <= (state_d == ST_ERROR) || (state_d == ST_LOCKOUT);
            lockout_led  <= (state_d == ST_LOCKOUT);
        end
    end

    assign state_code  = state_q;
    assign digit_count = cnt_q;
    assign tries_left  = tries_q;

endmodule

// File: tb/tb_code_lock_n.sv
// Bench for code_lock_n: vector table plus hand sequences for timeouts, programming and reset.
module tb_code_lock_n;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit;
    logic       enter;
    logic       prog;
    logic       locked_led, unlocked_led, error_led, lockout_led;
    logic [2:0] state_code, digit_count;
    logic [1:0] tries_left;

    code_lock_n dut (
        .clk(clk), .reset(reset), .digit(digit), .enter(enter), .prog(prog),
        .locked_led(locked_led), .unlocked_led(unlocked_led), .error_led(error_led),
        .lockout_led(lockout_led), .state_code(state_code), .digit_count(digit_count),
        .tries_left(tries_left)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] dc;
        logic [1:0] tl;
    } exp_t;

    typedef struct packed {
        logic [3:0] d;
        logic       p;
        exp_t       e;
    } vec_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    vec_t vecs[19];

    function automatic logic [3:0] leds_of(input logic [2:0] st);
        // {locked, unlocked, error, lockout}
        case (st)
            3'd0: leds_of = 4'b1000;
            3'd1: leds_of = 4'b0100;
            3'd2: leds_of = 4'b0010;
            3'd3: leds_of = 4'b0011;
            3'd4: leds_of = 4'b0100;
            default: leds_of = 4'b0000;
        endcase
    endfunction

    function automatic vec_t mk(input logic [3:0] d, input logic p,
                                input logic [2:0] st, input logic [2:0] dc, input logic [1:0] tl);
        vec_t v;
        v.d = d; v.p = p; v.e.st = st; v.e.dc = dc; v.e.tl = tl;
        return v;
    endfunction

    task automatic expect_out(input logic [2:0] st, input logic [2:0] dc, input logic [1:0] tl);
        exp_t e;
        e.st = st; e.dc = dc; e.tl = tl;
        q.push_back(e);
    endtask

    task automatic check_now(input string nm);
        exp_t       e;
        logic [3:0] leds_a;
        total++;
        if (q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = q.pop_front();
            leds_a = {locked_led, unlocked_led, error_led, lockout_led};
            if (state_code === e.st && digit_count === e.dc && tries_left === e.tl &&
                leds_a === leds_of(e.st))
                passed++;
            else
                $display("FAIL %s: got st=%0d dc=%0d tl=%0d leds=%b, want st=%0d dc=%0d tl=%0d leds=%b",
                         nm, state_code, digit_count, tries_left, leds_a,
                         e.st, e.dc, e.tl, leds_of(e.st));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d, input logic p,
                         input logic [2:0] st, input logic [2:0] dc, input logic [1:0] tl,
                         input string nm);
        expect_out(st, dc, tl);
        digit = d; prog = p; enter = 1'b1;
        idle(1);
        check_now(nm);
        enter = 1'b0; prog = 1'b0;
        idle(1);
    endtask

    task automatic do_reset(input string nm);
        expect_out(3'd0, 3'd0, 2'd3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_now(nm);
    endtask

    task automatic unlock_1234(input string nm);
        press(4'd1, 1'b0, 3'd0, 3'd1, 2'd3, {nm, "_d1"});
        press(4'd2, 1'b0, 3'd0, 3'd2, 2'd3, {nm, "_d2"});
        press(4'd3, 1'b0, 3'd0, 3'd3, 2'd3, {nm, "_d3"});
        press(4'd4, 1'b0, 3'd1, 3'd0, 2'd3, {nm, "_d4"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; digit = '0; enter = 1'b0; prog = 1'b0;
        vecs[0]  = mk(4'd1, 1'b0, 3'd0, 3'd1, 2'd3);
        vecs[1]  = mk(4'd2, 1'b1, 3'd0, 3'd2, 2'd3);
        vecs[2]  = mk(4'd3, 1'b0, 3'd0, 3'd3, 2'd3);
        vecs[3]  = mk(4'd4, 1'b0, 3'd1, 3'd0, 2'd3);
        vecs[4]  = mk(4'd0, 1'b0, 3'd0, 3'd0, 2'd3);
        vecs[5]  = mk(4'd1, 1'b0, 3'd0, 3'd1, 2'd3);
        vecs[6]  = mk(4'd2, 1'b0, 3'd0, 3'd2, 2'd3);
        vecs[7]  = mk(4'd3, 1'b0, 3'd0, 3'd3, 2'd3);
        vecs[8]  = mk(4'd5, 1'b0, 3'd2, 3'd0, 2'd2);
        vecs[9]  = mk(4'd1, 1'b0, 3'd0, 3'd0, 2'd2);
        vecs[10] = mk(4'd7, 1'b0, 3'd0, 3'd1, 2'd2);
        vecs[11] = mk(4'd2, 1'b0, 3'd0, 3'd2, 2'd2);
        vecs[12] = mk(4'd3, 1'b0, 3'd0, 3'd3, 2'd2);
        vecs[13] = mk(4'd4, 1'b0, 3'd2, 3'd0, 2'd1);
        vecs[14] = mk(4'd1, 1'b1, 3'd0, 3'd0, 2'd1);
        vecs[15] = mk(4'd1, 1'b0, 3'd0, 3'd1, 2'd1);
        vecs[16] = mk(4'd2, 1'b0, 3'd0, 3'd2, 2'd1);
        vecs[17] = mk(4'd3, 1'b0, 3'd0, 3'd3, 2'd1);
        vecs[18] = mk(4'd5, 1'b0, 3'd3, 3'd0, 2'd0);

        idle(2);
        do_reset("reset_init");

        for (int i = 0; i < 19; i++)
            press(vecs[i].d, vecs[i].p, vecs[i].e.st, vecs[i].e.dc, vecs[i].e.tl,
                  $sformatf("vec%0d", i));

        // Lockout entered at E0; the press task returned after E1.
        expect_out(3'd3, 3'd0, 2'd0);
        digit = 4'd1; enter = 1'b1;
        idle(1);
        check_now("lockout_press_ignored");
        enter = 1'b0;
        expect_out(3'd3, 3'd0, 2'd0);
        idle(997);
        check_now("lockout_999");
        expect_out(3'd0, 3'd0, 2'd3);
        idle(1);
        check_now("lockout_1000");

        unlock_1234("unl");
        expect_out(3'd1, 3'd0, 2'd3);
        idle(498);
        check_now("unlock_499");
        expect_out(3'd0, 3'd0, 2'd3);
        idle(1);
        check_now("unlock_500");

        unlock_1234("pg");
        press(4'd0, 1'b1, 3'd4, 3'd0, 2'd3, "pg_enter");
        press(4'd9, 1'b0, 3'd4, 3'd1, 2'd3, "pg_9");
        press(4'd8, 1'b1, 3'd4, 3'd2, 2'd3, "pg_8");
        press(4'd7, 1'b0, 3'd4, 3'd3, 2'd3, "pg_7");
        press(4'd6, 1'b0, 3'd0, 3'd0, 2'd3, "pg_6");
        press(4'd1, 1'b0, 3'd0, 3'd1, 2'd3, "old_1");
        press(4'd2, 1'b0, 3'd0, 3'd2, 2'd3, "old_2");
        press(4'd3, 1'b0, 3'd0, 3'd3, 2'd3, "old_3");
        press(4'd4, 1'b0, 3'd2, 3'd0, 2'd2, "old_4");
        press(4'd0, 1'b0, 3'd0, 3'd0, 2'd2, "old_clr");
        press(4'd9, 1'b0, 3'd0, 3'd1, 2'd2, "new_9");
        press(4'd8, 1'b0, 3'd0, 3'd2, 2'd2, "new_8");
        press(4'd7, 1'b0, 3'd0, 3'd3, 2'd2, "new_7");
        press(4'd6, 1'b0, 3'd1, 3'd0, 2'd3, "new_6");
        press(4'd0, 1'b0, 3'd0, 3'd0, 2'd3, "new_relock");

        do_reset("reset_code");
        press(4'd1, 1'b0, 3'd0, 3'd1, 2'd3, "mid_1");
        press(4'd2, 1'b0, 3'd0, 3'd2, 2'd3, "mid_2");
        do_reset("reset_mid_entry");
        unlock_1234("after_rst");

        press(4'd0, 1'b1, 3'd4, 3'd0, 2'd3, "pto_enter");
        press(4'd5, 1'b0, 3'd4, 3'd1, 2'd3, "pto_5a");
        press(4'd5, 1'b0, 3'd4, 3'd2, 2'd3, "pto_5b");
        expect_out(3'd4, 3'd2, 2'd3);
        idle(498);
        check_now("pto_499");
        expect_out(3'd0, 3'd0, 2'd3);
        idle(1);
        check_now("pto_500");
        unlock_1234("pto_code");

        press(4'd0, 1'b1, 3'd4, 3'd0, 2'd3, "prst_enter");
        press(4'd7, 1'b0, 3'd4, 3'd1, 2'd3, "prst_7a");
        press(4'd7, 1'b0, 3'd4, 3'd2, 2'd3, "prst_7b");
        do_reset("reset_mid_prog");
        unlock_1234("prst_code");
        press(4'd0, 1'b0, 3'd0, 3'd0, 2'd3, "relock");

        expect_out(3'd0, 3'd1, 2'd3);
        digit = 4'd1; enter = 1'b1;
        idle(20);
        check_now("held_enter");
        enter = 1'b0;
        idle(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
